// File: rtl/mdu_seq_pkg.sv
// ============================================================================
// Module  : mdu_seq_pkg
// Brief   : MDU op encodings, sequencer states and default latencies
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_seq_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Ops that start a multi-cycle busy period
  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_seq_if.sv
// ============================================================================
// Module  : mdu_seq_if
// Brief   : E-stage to MDU request/response bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mdu_seq_if #(
  parameter int WIDTH = 32
);

  logic [3:0]       MDUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             MDInD;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             MDStall;

  modport master (
    output MDUOp, A, B, MDInD,
    input  HI, LO, busy, MDStall
  );

  modport slave (
    input  MDUOp, A, B, MDInD,
    output HI, LO, busy, MDStall
  );

endinterface

`default_nettype wire

// File: rtl/mdu_seq_calc.sv
// ============================================================================
// Module  : mdu_calc
// Brief   : Combinational HI/LO result for the latched MDU op and operands
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_calc
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_wr
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_sdiv_b;
  logic [WIDTH-1:0]   w_udiv_b;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;

  assign w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // Signed divide on magnitudes; MIN / -1 naturally wraps back to MIN with rem 0
  assign w_b_zero = (i_b == '0);
  assign w_abs_a  = i_a[WIDTH-1] ? (-i_a) : i_a;
  assign w_abs_b  = i_b[WIDTH-1] ? (-i_b) : i_b;
  assign w_sdiv_b = w_b_zero ? C_ONE : w_abs_b;
  assign w_udiv_b = w_b_zero ? C_ONE : i_b;
  assign w_q_mag  = w_abs_a / w_sdiv_b;
  assign w_r_mag  = w_abs_a % w_sdiv_b;
  assign w_uq     = i_a / w_udiv_b;
  assign w_ur     = i_a % w_udiv_b;

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    o_wr = 1'b0;
    case (i_op)
      MDU_MULT: begin
        {o_hi, o_lo} = w_prod_s;
        o_wr         = 1'b1;
      end
      MDU_MULTU: begin
        {o_hi, o_lo} = w_prod_u;
        o_wr         = 1'b1;
      end
      MDU_DIV: begin
        o_lo = (i_a[WIDTH-1] ^ i_b[WIDTH-1]) ? (-w_q_mag) : w_q_mag;
        o_hi = i_a[WIDTH-1] ? (-w_r_mag) : w_r_mag;
        o_wr = ~w_b_zero;
      end
      MDU_DIVU: begin
        o_lo = w_uq;
        o_hi = w_ur;
        o_wr = ~w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
// Module  : mdu_seq
// Brief   : Multi-cycle mult/div sequencer owning HI/LO, with D-stage stall
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  mdu_seq_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  mdu_op_e          op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  mdu_op_e          w_op;
  logic             w_start;
  logic             w_busy;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_res_wr;

  assign w_op    = mdu_op_e'(bus.MDUOp);
  assign w_start = is_md_start(bus.MDUOp);
  assign w_busy  = (state_q == ST_RUN);

  mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .i_op (op_q),
    .i_a  (a_q),
    .i_b  (b_q),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo),
    .o_wr (w_res_wr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          op_d    = w_op;
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = ((w_op == MDU_MULT) || (w_op == MDU_MULTU)) ? C_MULT_CNT : C_DIV_CNT;
          state_d = ST_RUN;
        end else if (w_op == MDU_MTHI) begin
          hi_d = bus.A;
        end else if (w_op == MDU_MTLO) begin
          lo_d = bus.A;
        end
      end
      ST_RUN: begin
        // Requests arriving here are dropped; the result lands on the final count
        if (cnt_q == C_CNT_ONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (w_res_wr) begin
            hi_d = w_res_hi;
            lo_d = w_res_lo;
          end
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.busy    = w_busy;
  assign bus.MDStall = bus.MDInD & (w_busy | w_start);

endmodule

`default_nettype wire
